// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: word layout, default
// sizing, the halt opcode and the sequencer state encoding.
package instr_sequencer_pkg;

  localparam int WORD_W      = 16;
  localparam int OPC_W       = 4;
  localparam int OPC_LSB     = 0;
  localparam int OPD_W       = 12;
  localparam int OPD_LSB     = 4;
  localparam int CNT_W       = 8;
  localparam int SEQ_DEPTH   = 8;
  localparam int SEQ_TIMEOUT = 64;

  localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } seq_state_t;

  function automatic logic [OPC_W-1:0] get_opc(input logic [WORD_W-1:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [OPD_W-1:0] get_opd(input logic [WORD_W-1:0] w);
    return w[OPD_LSB +: OPD_W];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> core (fsm_control) handshake.
//   opcode/instr : issued instruction fields, held until the next fetch
//   inst_done    : fields valid for the core (ISSUE and WAIT)
//   issue        : one-cycle start pulse to the core
//   core_done    : one-cycle write-back complete pulse from the core
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic [OPD_W-1:0] instr;
  logic             inst_done;
  logic             issue;
  logic             core_done;

  modport master (output opcode, output instr, output inst_done, output issue,
                  input  core_done);
  modport slave  (input  opcode, input  instr, input  inst_done, input  issue,
                  output core_done);

endinterface

// File: rtl/instr_sequencer_seq_fifo.sv
// Program FIFO: synchronous, WIDTH x DEPTH, extended pointers.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : flush (wins over push)
//   push_i     : write wr_data_i; accepted when not full or popping same cycle
//   pop_i      : advance read pointer (ignored when empty)
//   rd_data_o  : head word (combinational read of head slot)
//   full_o, empty_o : status from pointer MSB compare
//   ovf_o      : push rejected this cycle
module seq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop_i && !empty_o;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign do_push   = push_i && (!full_o || do_pop);
  assign ovf_o     = push_i && !clear_i && full_o && !do_pop;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: assembles 16-bit words from a LSB-first serial port
// into the program FIFO and issues them to the core one at a time, in RUN
// (back-to-back) or STEP (one per step pulse) mode.
//   clk, rst      : clock, synchronous active-high reset
//   core_if       : master side of the core handshake (opcode/instr/
//                   inst_done/issue out, core_done in)
//   ser_in_i, ser_valid_i : serial load bit and qualifier
//   clear_prog_i  : flush FIFO, partial word and halted flag
//   run_mode_i    : 1 = RUN, 0 = STEP
//   step_pulse_i  : issue next instruction in STEP mode
//   busy_o, fifo_full_o, fifo_empty_o, halted_o : status
//   err_ovf_o, err_tmo_o : sticky errors (cleared only by rst)
//   instr_cnt_o   : issued instruction count, wraps
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a word plus RUN mode or a step pulse
// S_FETCH | pop head into opcode/instr; halt opcode stops here
// S_ISSUE | one-cycle start pulse to the core, count instruction
// S_WAIT  | wait for core_done or timeout
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH   = SEQ_DEPTH,
  parameter int TIMEOUT = SEQ_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  instr_sequencer_if.master  core_if,
  input  logic               ser_in_i,
  input  logic               ser_valid_i,
  input  logic               clear_prog_i,
  input  logic               run_mode_i,
  input  logic               step_pulse_i,
  output logic               busy_o,
  output logic               fifo_full_o,
  output logic               fifo_empty_o,
  output logic               halted_o,
  output logic               err_ovf_o,
  output logic               err_tmo_o,
  output logic [CNT_W-1:0]   instr_cnt_o
);
  localparam int IDX_W = $clog2(WORD_W);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WORD_W-1:0] shift_q;
  logic [IDX_W-1:0]  idx_q;
  logic              push_q;

  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty, fifo_ovf, fifo_pop;

  seq_state_t        state_q;
  logic [OPC_W-1:0]  opcode_q;
  logic [OPD_W-1:0]  operand_q;
  logic              inst_done_q, issue_q, busy_q, halted_q;
  logic              err_ovf_q, err_tmo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              start_d;

  // Serial assembler. The completed word sits in shift_q and is pushed on the
  // following edge; a new bit 0 written on that same edge does not disturb
  // the value the FIFO samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      push_q  <= 1'b0;
    end else if (clear_prog_i) begin
      idx_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (ser_valid_i) begin
        shift_q[idx_q] <= ser_in_i;
        if (idx_q == IDX_LAST) begin
          idx_q  <= '0;
          push_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IDX_ONE;
        end
      end
    end
  end

  assign fifo_pop = (state_q == S_FETCH);

  seq_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear_prog_i),
    .push_i    (push_q),
    .pop_i     (fifo_pop),
    .wr_data_i (shift_q),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ovf_o     (fifo_ovf)
  );

  // A clear in the same cycle empties the FIFO, so no fetch may start.
  assign start_d = !fifo_empty && !halted_q && !clear_prog_i &&
                   (run_mode_i || step_pulse_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      operand_q   <= '0;
      inst_done_q <= 1'b0;
      issue_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      cnt_q       <= '0;
      tmr_q       <= '0;
    end else begin
      issue_q <= 1'b0;
      if (fifo_ovf)     err_ovf_q <= 1'b1;
      if (clear_prog_i) halted_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_d) state_q <= S_FETCH;
        end
        S_FETCH: begin
          opcode_q  <= get_opc(fifo_head);
          operand_q <= get_opd(fifo_head);
          if (get_opc(fifo_head) == HALT_OPC) begin
            if (!clear_prog_i) halted_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            // issue/inst_done/busy are registered so they appear with ISSUE.
            issue_q     <= 1'b1;
            inst_done_q <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= cnt_q + CNT_ONE;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr_q   <= TMR_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (core_if.core_done) begin
            inst_done_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else if (tmr_q == '0) begin
            err_tmo_q   <= 1'b1;
            inst_done_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            tmr_q <= tmr_q - TMR_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_if.opcode    = opcode_q;
  assign core_if.instr     = operand_q;
  assign core_if.inst_done = inst_done_q;
  assign core_if.issue     = issue_q;
  assign busy_o            = busy_q;
  assign fifo_full_o       = fifo_full;
  assign fifo_empty_o      = fifo_empty;
  assign halted_o          = halted_q;
  assign err_ovf_o         = err_ovf_q;
  assign err_tmo_o         = err_tmo_q;
  assign instr_cnt_o       = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_in = 1'b0, ser_valid = 1'b0, clear_prog = 1'b0;
  logic       run_mode = 1'b0, step_pulse = 1'b0;
  logic       busy, fifo_full, fifo_empty, halted, err_ovf, err_tmo;
  logic [7:0] instr_cnt;

  always #5 clk = ~clk;

  instr_sequencer_if core_if();

  instr_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .core_if      (core_if),
    .ser_in_i     (ser_in),
    .ser_valid_i  (ser_valid),
    .clear_prog_i (clear_prog),
    .run_mode_i   (run_mode),
    .step_pulse_i (step_pulse),
    .busy_o       (busy),
    .fifo_full_o  (fifo_full),
    .fifo_empty_o (fifo_empty),
    .halted_o     (halted),
    .err_ovf_o    (err_ovf),
    .err_tmo_o    (err_tmo),
    .instr_cnt_o  (instr_cnt)
  );

  typedef struct {
    logic [15:0] word;
    logic [3:0]  opc;
    logic [11:0] opd;
  } vec_t;

  vec_t        vecs[4];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0;
  int          n_issue = 0;
  int          core_lat = 0;
  int          exp_cnt = 0;
  int          base, k;
  logic [15:0] sb_q[$];
  logic [15:0] sb_w;
  logic [15:0] w;
  int          issue_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every issue pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && core_if.issue === 1'b1) begin
      n_issue++;
      issue_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("sb_unexpected_issue", 32'd1, 32'd0);
      end else begin
        sb_w = sb_q.pop_front();
        check("sb_opcode", {28'd0, core_if.opcode}, {28'd0, sb_w[3:0]});
        check("sb_instr", {20'd0, core_if.instr}, {20'd0, sb_w[15:4]});
      end
    end
  end

  // Core model: core_done core_lat cycles after issue; core_lat==0 never answers.
  initial begin
    int lat;
    core_if.core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && core_if.issue === 1'b1 && core_lat > 0) begin
        lat = core_lat;
        repeat (lat) @(posedge clk);
        #1 core_if.core_done = 1'b1;
        @(posedge clk);
        #1 core_if.core_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] wd);
    for (int i = 0; i < 16; i++) begin
      ser_in    = wd[i];
      ser_valid = 1'b1;
      tick();
    end
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    tick();
  endtask

  task automatic do_step();
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_issues(input int target, input int budget, input string name);
    int n = 0;
    while (n_issue < target && n < budget) begin
      tick();
      n++;
    end
    check(name, n_issue, target);
  endtask

  initial begin
    vecs[0] = '{word: 16'h1238, opc: 4'h8, opd: 12'h123};
    vecs[1] = '{word: 16'hA5C3, opc: 4'h3, opd: 12'hA5C};
    vecs[2] = '{word: 16'h0001, opc: 4'h1, opd: 12'h000};
    vecs[3] = '{word: 16'hFFFE, opc: 4'hE, opd: 12'hFFF};

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_opcode", {28'd0, core_if.opcode}, 32'd0);
    check("rst_instr", {20'd0, core_if.instr}, 32'd0);
    check("rst_inst_done", {31'd0, core_if.inst_done}, 32'd0);
    check("rst_issue", {31'd0, core_if.issue}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    check("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
    check("rst_err_tmo", {31'd0, err_tmo}, 32'd0);
    check("rst_instr_cnt", {24'd0, instr_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // STEP mode, table driven: issue two cycles after the step pulse
    run_mode = 1'b0;
    core_lat = 5;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(vecs[i].word);
      send_word(vecs[i].word);
      check("step_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
      step_pulse = 1'b1;
      tick();
      step_pulse = 1'b0;
      check("step_no_early_issue", {31'd0, core_if.issue}, 32'd0);
      tick();
      exp_cnt++;
      check("step_issue", {31'd0, core_if.issue}, 32'd1);
      check("step_opcode", {28'd0, core_if.opcode}, {28'd0, vecs[i].opc});
      check("step_instr", {20'd0, core_if.instr}, {20'd0, vecs[i].opd});
      check("step_inst_done", {31'd0, core_if.inst_done}, 32'd1);
      check("step_busy", {31'd0, busy}, 32'd1);
      check("step_instr_cnt", {24'd0, instr_cnt}, exp_cnt);
      tick();
      check("step_issue_one_cycle", {31'd0, core_if.issue}, 32'd0);
      wait_idle(40, "step_idle");
      check("step_fifo_empty", {31'd0, fifo_empty}, 32'd1);
      check("step_inst_done_low", {31'd0, core_if.inst_done}, 32'd0);
    end

    // RUN mode: core latency 10 -> issues 13 cycles apart
    core_lat = 10;
    sb_q.push_back(16'h1111); send_word(16'h1111);
    sb_q.push_back(16'h2222); send_word(16'h2222);
    sb_q.push_back(16'h3334); send_word(16'h3334);
    issue_cyc_q.delete();
    base = n_issue;
    run_mode = 1'b1;
    wait_issues(base + 3, 100, "run_issues");
    wait_idle(40, "run_idle");
    run_mode = 1'b0;
    if (issue_cyc_q.size() == 3) begin
      check("run_gap1", issue_cyc_q[1] - issue_cyc_q[0], 32'd13);
      check("run_gap2", issue_cyc_q[2] - issue_cyc_q[1], 32'd13);
    end
    check("run_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    exp_cnt += 3;
    check("run_instr_cnt", {24'd0, instr_cnt}, exp_cnt);

    // Overflow: DEPTH+1 words with no pop
    core_lat = 3;
    for (int i = 0; i < 9; i++) begin
      w = {12'(i * 17 + 5), 4'(i)};
      if (i < 8) sb_q.push_back(w);
      send_word(w);
      if (i == 7) begin
        check("ovf_full_at_depth", {31'd0, fifo_full}, 32'd1);
        check("ovf_no_err_at_depth", {31'd0, err_ovf}, 32'd0);
      end
    end
    check("ovf_full", {31'd0, fifo_full}, 32'd1);
    check("ovf_err", {31'd0, err_ovf}, 32'd1);
    base = n_issue;
    run_mode = 1'b1;
    wait_issues(base + 8, 200, "ovf_issues");
    wait_idle(20, "ovf_idle");
    run_mode = 1'b0;
    check("ovf_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    check("ovf_err_sticky", {31'd0, err_ovf}, 32'd1);
    exp_cnt += 8;
    check("ovf_instr_cnt", {24'd0, instr_cnt}, exp_cnt);

    // Halt opcode stops RUN mode
    core_lat = 4;
    sb_q.push_back(16'h0010);
    send_word(16'h0010);
    send_word(16'h000F);
    send_word(16'h0020);
    base = n_issue;
    run_mode = 1'b1;
    wait_issues(base + 1, 50, "halt_first_issue");
    repeat (20) tick();
    check("halt_single_issue", n_issue, base + 1);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
    check("halt_busy", {31'd0, busy}, 32'd0);
    exp_cnt++;
    check("halt_instr_cnt", {24'd0, instr_cnt}, exp_cnt);
    run_mode = 1'b0;
    clear_prog = 1'b1;
    tick();
    clear_prog = 1'b0;
    check("clear_halted", {31'd0, halted}, 32'd0);
    check("clear_fifo_empty", {31'd0, fifo_empty}, 32'd1);

    // Timeout: no core_done -> 1 ISSUE + 64 WAIT cycles, then next word issues
    core_lat = 0;
    sb_q.push_back(16'h4561); send_word(16'h4561);
    sb_q.push_back(16'h7892); send_word(16'h7892);
    do_step();
    check("tmo_issue", {31'd0, core_if.issue}, 32'd1);
    exp_cnt++;
    k = 0;
    while (busy && k < 100) begin
      if (k == 10) step_pulse = 1'b1;
      tick();
      step_pulse = 1'b0;
      k++;
    end
    check("tmo_busy_cycles", k, 32'd65);
    check("tmo_err", {31'd0, err_tmo}, 32'd1);
    check("tmo_inst_done_low", {31'd0, core_if.inst_done}, 32'd0);
    base = n_issue;
    repeat (4) tick();
    check("tmo_step_not_queued", n_issue, base);
    core_lat = 3;
    do_step();
    check("tmo_next_issue", {31'd0, core_if.issue}, 32'd1);
    exp_cnt++;
    wait_idle(20, "tmo_next_idle");
    check("tmo_err_sticky", {31'd0, err_tmo}, 32'd1);
    check("tmo_instr_cnt", {24'd0, instr_cnt}, exp_cnt);

    // rst during WAIT
    core_lat = 0;
    sb_q.push_back(16'h3333);
    send_word(16'h3333);
    do_step();
    check("rstw_issue", {31'd0, core_if.issue}, 32'd1);
    repeat (5) tick();
    check("rstw_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("rstw_issue_low", {31'd0, core_if.issue}, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_inst_done", {31'd0, core_if.inst_done}, 32'd0);
    check("rstw_opcode", {28'd0, core_if.opcode}, 32'd0);
    check("rstw_instr", {20'd0, core_if.instr}, 32'd0);
    check("rstw_instr_cnt", {24'd0, instr_cnt}, 32'd0);
    check("rstw_err_tmo", {31'd0, err_tmo}, 32'd0);
    check("rstw_err_ovf", {31'd0, err_ovf}, 32'd0);
    check("rstw_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    rst = 1'b0;
    exp_cnt = 0;
    tick();

    // clear_prog mid-word discards the partial word
    w = 16'hABCD;
    for (int i = 0; i < 8; i++) begin
      ser_in    = w[i];
      ser_valid = 1'b1;
      tick();
    end
    ser_valid  = 1'b0;
    clear_prog = 1'b1;
    tick();
    clear_prog = 1'b0;
    tick();
    check("partial_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    sb_q.push_back(16'h0235);
    send_word(16'h0235);
    check("partial_fifo_one", {31'd0, fifo_empty}, 32'd0);
    core_lat = 3;
    do_step();
    exp_cnt++;
    check("partial_issue", {31'd0, core_if.issue}, 32'd1);
    check("partial_opcode", {28'd0, core_if.opcode}, 32'h5);
    check("partial_instr", {20'd0, core_if.instr}, 32'h023);
    check("partial_instr_cnt", {24'd0, instr_cnt}, exp_cnt);
    wait_idle(20, "partial_idle");
    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
